// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: arbitrates, registers operands, traps illegal opcodes, returns a tagged response.
// Optional build macro ALU_ARB_FIXED_PRIO_EN: req0 always wins a tie (no round-robin pointer).
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [OP_WIDTH-1:0]   req0_op,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [OP_WIDTH-1:0]   req1_op,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,

    output logic [OP_WIDTH-1:0]   alu_operation,
    output logic [DATA_WIDTH-1:0] alu_in_x,
    output logic [DATA_WIDTH-1:0] alu_in_y,
    input  logic [DATA_WIDTH-1:0] alu_out_s,
    input  logic                  alu_zr,
    input  logic                  alu_ng,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_zr,
    output logic                  rsp_ng,
    output logic                  rsp_err
);

    localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(4'b0000);
    localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(4'b0001);
    localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(4'b0010);
    localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(4'b0110);
    localparam logic [OP_WIDTH-1:0] OP_SLT = OP_WIDTH'(4'b0111);
    localparam logic [OP_WIDTH-1:0] OP_NOR = OP_WIDTH'(4'b1100);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_legal(input logic [OP_WIDTH-1:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    state_t                state_q, state_d;
    logic [OP_WIDTH-1:0]   op_q, op_d;
    logic [DATA_WIDTH-1:0] x_q, x_d;
    logic [DATA_WIDTH-1:0] y_q, y_d;
    logic                  id_q, id_d;
    logic                  illegal_q, illegal_d;
    logic                  rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic                  rsp_zr_q, rsp_zr_d;
    logic                  rsp_ng_q, rsp_ng_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  grant0, grant1;
    logic                  accept_en, take;
    logic [OP_WIDTH-1:0]   sel_op;
    logic [DATA_WIDTH-1:0] sel_a, sel_b;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid && !req0_valid;
    end
`else
    logic rr_ptr_q, rr_ptr_d;

    // rr_ptr_q = 1 means req1 wins the next tie
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if (rr_ptr_q) grant1 = 1'b1;
            else          grant0 = 1'b1;
        end else if (req0_valid) begin
            grant0 = 1'b1;
        end else if (req1_valid) begin
            grant1 = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (take) rr_ptr_d = grant0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rr_ptr_q <= 1'b0;
        else          rr_ptr_q <= rr_ptr_d;
    end
`endif

    assign take   = accept_en && (grant0 || grant1);
    assign sel_op = grant1 ? req1_op : req0_op;
    assign sel_a  = grant1 ? req1_a  : req0_a;
    assign sel_b  = grant1 ? req1_b  : req0_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = take ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready is masked while reset is held so no handshake is seen mid-reset
    always_comb begin
        accept_en = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: accept_en = 1'b1;
            RESP: begin
                rsp_valid = 1'b1;
                accept_en = rsp_ready;
            end
            default: ;
        endcase
        req0_ready = reset_n && accept_en && grant0;
        req1_ready = reset_n && accept_en && grant1;
    end

    // An illegal opcode leaves the ALU operand registers untouched
    always_comb begin
        op_d         = op_q;
        x_d          = x_q;
        y_d          = y_q;
        id_d         = id_q;
        illegal_d    = illegal_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zr_d     = rsp_zr_q;
        rsp_ng_d     = rsp_ng_q;
        rsp_err_d    = rsp_err_q;
        if (take) begin
            id_d      = grant1;
            illegal_d = !is_legal(sel_op);
            if (is_legal(sel_op)) begin
                op_d = sel_op;
                x_d  = sel_a;
                y_d  = sel_b;
            end
        end
        if (state_q == EXEC) begin
            rsp_id_d  = id_q;
            rsp_err_d = illegal_q;
            if (illegal_q) begin
                rsp_result_d = '0;
                rsp_zr_d     = 1'b0;
                rsp_ng_d     = 1'b0;
            end else begin
                rsp_result_d = alu_out_s;
                rsp_zr_d     = alu_zr;
                rsp_ng_d     = alu_ng;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            id_q         <= 1'b0;
            illegal_q    <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zr_q     <= 1'b0;
            rsp_ng_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            op_q         <= op_d;
            x_q          <= x_d;
            y_q          <= y_d;
            id_q         <= id_d;
            illegal_q    <= illegal_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zr_q     <= rsp_zr_d;
            rsp_ng_q     <= rsp_ng_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_operation = op_q;
    assign alu_in_x      = x_q;
    assign alu_in_y      = y_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_zr        = rsp_zr_q;
    assign rsp_ng        = rsp_ng_q;
    assign rsp_err       = rsp_err_q;

endmodule
